// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer datapath.
// Holds the default neuron width, layer size and lane count, the neuron_t
// type, and the relu() helper. The helper is only used by builds that define
// NEURON_RELU_EN.
package fc_pkg;

    localparam int FC_SIZE     = 16;
    localparam int FC_LAYER_SZ = 10;
    localparam int FC_LANES    = 2;

    typedef logic signed [FC_SIZE-1:0] neuron_t;

    // Clamp a two's-complement neuron value at zero.
    function automatic neuron_t relu(input neuron_t v);
        neuron_t r;
        if (v[FC_SIZE-1] == 1'b1) begin
            r = '0;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/neuron_bank.sv
// One neuron bank: a LAYER_SZ x SIZE register array with a multi-lane write
// port, a per-neuron written mask and its popcount.
// - When several lanes hit the same neuron, the highest lane index wins.
// - The caller guarantees that every enabled lane carries an in-range address.
// - clr clears the data and the mask, and has priority over writes.
module neuron_bank #(
    parameter int SIZE     = 16,
    parameter int LAYER_SZ = 10,
    parameter int LANES    = 2,
    parameter int ADDR_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic [LANES-1:0]           we,
    input  logic [LANES*SIZE-1:0]      wdata,
    input  logic [LANES*ADDR_W-1:0]    waddr,
    output logic [LAYER_SZ*SIZE-1:0]   data,
    output logic [ADDR_W:0]            count
);

    logic [SIZE-1:0]     mem_r [LAYER_SZ];
    logic [LAYER_SZ-1:0] mask_r;

    // Storage and written mask. Lanes are visited in ascending order, so the
    // last non-blocking assignment (the highest lane) takes effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < LAYER_SZ; n++) begin
                mem_r[n] <= '0;
            end
            mask_r <= '0;
        end else if (clr) begin
            for (int n = 0; n < LAYER_SZ; n++) begin
                mem_r[n] <= '0;
            end
            mask_r <= '0;
        end else begin
            for (int n = 0; n < LAYER_SZ; n++) begin
                for (int i = 0; i < LANES; i++) begin
                    if (we[i] && (waddr[i*ADDR_W +: ADDR_W] == ADDR_W'(n))) begin
                        mem_r[n]  <= wdata[i*SIZE +: SIZE];
                        mask_r[n] <= 1'b1;
                    end
                end
            end
        end
    end

    // Flatten the array and count the distinct neurons written so far.
    always_comb begin
        data  = '0;
        count = '0;
        for (int n = 0; n < LAYER_SZ; n++) begin
            data[n*SIZE +: SIZE] = mem_r[n];
            count = count + {{ADDR_W{1'b0}}, mask_r[n]};
        end
    end

endmodule

// File: rtl/neuron_layer_pingpong.sv
// Double-buffered neuron value store for a fully-connected layer.
// - The upstream side fills the write bank over LANES ports and closes it
//   with load_last.
// - A swap hands the full write bank to the read side, where the downstream
//   layer sees it as values/values_valid.
// - Optional build macro NEURON_RELU_EN: accepted writes are clamped at zero
//   (signed) before they are stored.
module neuron_layer_pingpong
    import fc_pkg::*;
#(
    parameter  int SIZE     = FC_SIZE,
    parameter  int LAYER_SZ = FC_LAYER_SZ,
    parameter  int LANES    = FC_LANES,
    localparam int ADDR_W   = $clog2(LAYER_SZ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LANES-1:0]          load_en,
    input  logic [LANES*SIZE-1:0]     load_value,
    input  logic [LANES*ADDR_W-1:0]   load_address,
    input  logic                      load_last,
    output logic                      fill_ready,
    output logic [ADDR_W:0]           fill_count,
    output logic [LAYER_SZ*SIZE-1:0]  values,
    output logic                      values_valid,
    input  logic                      consume,
    output logic                      load_drop
);

    logic                     wr_sel_r;
    logic                     wr_full_r;
    logic                     rd_valid_r;
    logic                     load_drop_r;

    logic [LANES-1:0]         accept_s;
    logic                     drop_s;
    logic [LANES*SIZE-1:0]    wdata_s;
    logic                     swap_s;
    logic [LANES-1:0]         we0_s;
    logic [LANES-1:0]         we1_s;
    logic                     clr0_s;
    logic                     clr1_s;
    logic [LAYER_SZ*SIZE-1:0] data0_s;
    logic [LAYER_SZ*SIZE-1:0] data1_s;
    logic [ADDR_W:0]          count0_s;
    logic [ADDR_W:0]          count1_s;

    // Per-lane acceptance, discard detection and the stored-value transform.
    always_comb begin
        accept_s = '0;
        drop_s   = 1'b0;
        wdata_s  = '0;
        for (int i = 0; i < LANES; i++) begin
            if (load_en[i]) begin
                if (!wr_full_r &&
                    ({1'b0, load_address[i*ADDR_W +: ADDR_W]} < (ADDR_W+1)'(LAYER_SZ))) begin
                    accept_s[i] = 1'b1;
                end else begin
                    drop_s = 1'b1;
                end
            end else begin
                accept_s[i] = 1'b0;
            end
`ifdef NEURON_RELU_EN
            wdata_s[i*SIZE +: SIZE] = relu(load_value[i*SIZE +: SIZE]);
`else
            wdata_s[i*SIZE +: SIZE] = load_value[i*SIZE +: SIZE];
`endif
        end
    end

    // Route writes to the current write bank and clear the bank that becomes
    // the write bank when a swap happens.
    always_comb begin
        swap_s = wr_full_r && (!rd_valid_r || consume);
        if (wr_sel_r) begin
            we0_s  = '0;
            we1_s  = accept_s;
            clr0_s = swap_s;
            clr1_s = 1'b0;
        end else begin
            we0_s  = accept_s;
            we1_s  = '0;
            clr0_s = 1'b0;
            clr1_s = swap_s;
        end
    end

    // Bank-select, close, read-valid and drop-pulse state.
    // A swap takes priority over consume, so a pending layer streams in with
    // no invalid gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel_r    <= 1'b0;
            wr_full_r   <= 1'b0;
            rd_valid_r  <= 1'b0;
            load_drop_r <= 1'b0;
        end else begin
            load_drop_r <= drop_s;
            if (swap_s) begin
                wr_sel_r   <= ~wr_sel_r;
                wr_full_r  <= 1'b0;
                rd_valid_r <= 1'b1;
            end else begin
                if (!wr_full_r && load_last) begin
                    wr_full_r <= 1'b1;
                end else begin
                    wr_full_r <= wr_full_r;
                end
                if (consume) begin
                    rd_valid_r <= 1'b0;
                end else begin
                    rd_valid_r <= rd_valid_r;
                end
            end
        end
    end

    neuron_bank #(
        .SIZE     (SIZE),
        .LAYER_SZ (LAYER_SZ),
        .LANES    (LANES),
        .ADDR_W   (ADDR_W)
    ) u_bank0 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr0_s),
        .we    (we0_s),
        .wdata (wdata_s),
        .waddr (load_address),
        .data  (data0_s),
        .count (count0_s)
    );

    neuron_bank #(
        .SIZE     (SIZE),
        .LAYER_SZ (LAYER_SZ),
        .LANES    (LANES),
        .ADDR_W   (ADDR_W)
    ) u_bank1 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr1_s),
        .we    (we1_s),
        .wdata (wdata_s),
        .waddr (load_address),
        .data  (data1_s),
        .count (count1_s)
    );

    assign fill_ready   = ~wr_full_r;
    assign values_valid = rd_valid_r;
    assign load_drop    = load_drop_r;
    assign values       = wr_sel_r ? data0_s : data1_s;
    assign fill_count   = wr_sel_r ? count1_s : count0_s;

endmodule

// File: tb/tb_neuron_layer_pingpong.sv
// Directed bench for neuron_layer_pingpong with table-driven vectors plus an
// asynchronous-reset sequence.
module tb_neuron_layer_pingpong;

    localparam int SIZE     = 16;
    localparam int LAYER_SZ = 10;
    localparam int LANES    = 2;
    localparam int ADDR_W   = 4;

    logic                      clk;
    logic                      rst_n;
    logic [LANES-1:0]          load_en;
    logic [LANES*SIZE-1:0]     load_value;
    logic [LANES*ADDR_W-1:0]   load_address;
    logic                      load_last;
    logic                      fill_ready;
    logic [ADDR_W:0]           fill_count;
    logic [LAYER_SZ*SIZE-1:0]  values;
    logic                      values_valid;
    logic                      consume;
    logic                      load_drop;

    int n_checks = 0;
    int n_fail   = 0;

    neuron_layer_pingpong dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_en      (load_en),
        .load_value   (load_value),
        .load_address (load_address),
        .load_last    (load_last),
        .fill_ready   (fill_ready),
        .fill_count   (fill_count),
        .values       (values),
        .values_valid (values_valid),
        .consume      (consume),
        .load_drop    (load_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  en;
        logic [3:0]  a0;
        logic [15:0] v0;
        logic [3:0]  a1;
        logic [15:0] v1;
        logic        last;
        logic        cons;
        logic        e_ready;
        logic [4:0]  e_count;
        logic        e_valid;
        logic        e_drop;
        int          chk_idx;
        logic [15:0] e_val;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] en, input logic [3:0] a0,
                                input logic [15:0] v0, input logic [3:0] a1,
                                input logic [15:0] v1, input logic last,
                                input logic cons, input logic r, input logic [4:0] c,
                                input logic v, input logic d, input int idx,
                                input logic [15:0] val);
        vec_t t;
        t.en = en; t.a0 = a0; t.v0 = v0; t.a1 = a1; t.v1 = v1;
        t.last = last; t.cons = cons; t.e_ready = r; t.e_count = c;
        t.e_valid = v; t.e_drop = d; t.chk_idx = idx; t.e_val = val;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] val_at(input int idx);
        return values[idx*SIZE +: SIZE];
    endfunction

    task automatic drive(input logic [1:0] en, input logic [3:0] a0, input logic [15:0] v0,
                         input logic [3:0] a1, input logic [15:0] v1,
                         input logic last, input logic cons);
        load_en      = en;
        load_address = {a1, a0};
        load_value   = {v1, v0};
        load_last    = last;
        consume      = cons;
    endtask

    logic [15:0] relu_exp;

    initial begin
`ifdef NEURON_RELU_EN
        relu_exp = 16'h0000;
`else
        relu_exp = 16'hFFF0;
`endif
        // en a0 v0 a1 v1 last cons | ready count valid drop | idx val
        vecs.push_back(mk(2'b11, 4'd0, 16'd1, 4'd1, 16'd2,  1'b0, 1'b0, 1'b1, 5'd2,  1'b0, 1'b0, -1, 16'd0));
        vecs.push_back(mk(2'b11, 4'd2, 16'd3, 4'd3, 16'd4,  1'b0, 1'b0, 1'b1, 5'd4,  1'b0, 1'b0, -1, 16'd0));
        vecs.push_back(mk(2'b11, 4'd4, 16'd5, 4'd5, 16'd6,  1'b0, 1'b0, 1'b1, 5'd6,  1'b0, 1'b0, -1, 16'd0));
        vecs.push_back(mk(2'b11, 4'd6, 16'd7, 4'd7, 16'd8,  1'b0, 1'b0, 1'b1, 5'd8,  1'b0, 1'b0, -1, 16'd0));
        vecs.push_back(mk(2'b11, 4'd8, 16'd9, 4'd9, 16'd10, 1'b1, 1'b0, 1'b0, 5'd10, 1'b0, 1'b0, -1, 16'd0));
        vecs.push_back(mk(2'b00, 4'd0, 16'd0, 4'd0, 16'd0,  1'b0, 1'b0, 1'b1, 5'd0,  1'b1, 1'b0, 3, 16'd4));
        vecs.push_back(mk(2'b00, 4'd0, 16'd0, 4'd0, 16'd0,  1'b0, 1'b0, 1'b1, 5'd0,  1'b1, 1'b0, 9, 16'd10));
        // collision on addr 2: lane1 wins, counted once
        vecs.push_back(mk(2'b11, 4'd2, 16'h0011, 4'd2, 16'h0022, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1, 1'b0, 3, 16'd4));
        // close layer 2 while layer 1 still held -> backpressure
        vecs.push_back(mk(2'b00, 4'd0, 16'd0, 4'd0, 16'd0,  1'b1, 1'b0, 1'b0, 5'd1,  1'b1, 1'b0, -1, 16'd0));
        vecs.push_back(mk(2'b01, 4'd0, 16'h55, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 5'd1,  1'b1, 1'b1, 3, 16'd4));
        vecs.push_back(mk(2'b00, 4'd0, 16'd0, 4'd0, 16'd0,  1'b0, 1'b0, 1'b0, 5'd1,  1'b1, 1'b0, -1, 16'd0));
        vecs.push_back(mk(2'b00, 4'd0, 16'd0, 4'd0, 16'd0,  1'b0, 1'b1, 1'b1, 5'd0,  1'b1, 1'b0, 2, 16'h0022));
        vecs.push_back(mk(2'b00, 4'd0, 16'd0, 4'd0, 16'd0,  1'b0, 1'b0, 1'b1, 5'd0,  1'b1, 1'b0, 3, 16'd0));
        // out-of-range addresses on each lane
        vecs.push_back(mk(2'b01, 4'd12, 16'd5, 4'd0, 16'd0, 1'b0, 1'b0, 1'b1, 5'd0,  1'b1, 1'b1, -1, 16'd0));
        vecs.push_back(mk(2'b10, 4'd0, 16'd0, 4'd15, 16'd5, 1'b0, 1'b0, 1'b1, 5'd0,  1'b1, 1'b1, -1, 16'd0));
        vecs.push_back(mk(2'b00, 4'd0, 16'd0, 4'd0, 16'd0,  1'b0, 1'b0, 1'b1, 5'd0,  1'b1, 1'b0, -1, 16'd0));
        // consume without pending swap, then consume while empty
        vecs.push_back(mk(2'b00, 4'd0, 16'd0, 4'd0, 16'd0,  1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, -1, 16'd0));
        vecs.push_back(mk(2'b00, 4'd0, 16'd0, 4'd0, 16'd0,  1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, -1, 16'd0));
        // negative value, optional clamp
        vecs.push_back(mk(2'b11, 4'd1, 16'hFFF0, 4'd2, 16'd5, 1'b1, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, -1, 16'd0));
        vecs.push_back(mk(2'b00, 4'd0, 16'd0, 4'd0, 16'd0,  1'b0, 1'b0, 1'b1, 5'd0,  1'b1, 1'b0, 1, relu_exp));
        vecs.push_back(mk(2'b00, 4'd0, 16'd0, 4'd0, 16'd0,  1'b0, 1'b0, 1'b1, 5'd0,  1'b1, 1'b0, 2, 16'd5));
        // back-to-back: consume with pending swap keeps values_valid high
        vecs.push_back(mk(2'b01, 4'd0, 16'd7, 4'd0, 16'd0,  1'b1, 1'b0, 1'b0, 5'd1,  1'b1, 1'b0, 1, relu_exp));
        vecs.push_back(mk(2'b00, 4'd0, 16'd0, 4'd0, 16'd0,  1'b0, 1'b1, 1'b1, 5'd0,  1'b1, 1'b0, 0, 16'd7));

        rst_n = 1'b0;
        drive(2'b00, 4'd0, 16'd0, 4'd0, 16'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_fill_ready", 32'(fill_ready), 32'd1);
        check("reset_fill_count", 32'(fill_count), 32'd0);
        check("reset_values_valid", 32'(values_valid), 32'd0);
        check("reset_load_drop", 32'(load_drop), 32'd0);

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].en, vecs[k].a0, vecs[k].v0, vecs[k].a1, vecs[k].v1,
                  vecs[k].last, vecs[k].cons);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_fill_ready", k), 32'(fill_ready), 32'(vecs[k].e_ready));
            check($sformatf("v%0d_fill_count", k), 32'(fill_count), 32'(vecs[k].e_count));
            check($sformatf("v%0d_values_valid", k), 32'(values_valid), 32'(vecs[k].e_valid));
            check($sformatf("v%0d_load_drop", k), 32'(load_drop), 32'(vecs[k].e_drop));
            if (vecs[k].chk_idx >= 0) begin
                check($sformatf("v%0d_values[%0d]", k, vecs[k].chk_idx),
                      32'(val_at(vecs[k].chk_idx)), 32'(vecs[k].e_val));
            end
        end

        // Async reset in the middle of a fill: five writes, then reset between edges.
        drive(2'b11, 4'd3, 16'd1, 4'd4, 16'd2, 1'b0, 1'b0);
        @(posedge clk); @(negedge clk);
        drive(2'b11, 4'd5, 16'd3, 4'd6, 16'd4, 1'b0, 1'b0);
        @(posedge clk); @(negedge clk);
        drive(2'b01, 4'd7, 16'd5, 4'd0, 16'd0, 1'b0, 1'b0);
        @(posedge clk); @(negedge clk);
        check("midfill_count", 32'(fill_count), 32'd5);
        check("midfill_valid", 32'(values_valid), 32'd1);
        drive(2'b00, 4'd0, 16'd0, 4'd0, 16'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_fill_count", 32'(fill_count), 32'd0);
        check("async_rst_values_valid", 32'(values_valid), 32'd0);
        check("async_rst_fill_ready", 32'(fill_ready), 32'd1);
        check("async_rst_values0", 32'(val_at(0)), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("post_rst_fill_count", 32'(fill_count), 32'd0);
        check("post_rst_values_valid", 32'(values_valid), 32'd0);
        check("post_rst_load_drop", 32'(load_drop), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
